// File: rtl/run_dump_controller_pkg.sv
// run_dump_pkg
// Shared definitions for the end-of-run monitor:
//   - record tag values carried on o_dump_tag (PC, HDR, REG, MEM)
//   - halt cause values carried on o_halt_cause (none, zero instruction, timeout)
//   - controller state encoding (RUN, HDR, REGS, MEM, DONE)
package run_dump_pkg;

  localparam logic [1:0] TAG_PC  = 2'd0;
  localparam logic [1:0] TAG_HDR = 2'd1;
  localparam logic [1:0] TAG_REG = 2'd2;
  localparam logic [1:0] TAG_MEM = 2'd3;

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_ZERO    = 2'd1;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

  typedef enum logic [2:0] {
    RUN,
    HDR,
    REGS,
    MEM,
    DONE
  } dumpState_t;

endpackage

// File: rtl/run_dump_controller_seq_counter.sv
// dump_seq_counter
// Index counter that walks the register and memory sections of the dump.
// It advances once per accepted record and wraps back to zero after the
// terminal value, so the next section always starts from index 0.
// Ports:
//   i_clk      - clock, rising edge
//   i_reset    - synchronous active-high reset
//   i_clear    - hold the index at zero (used outside the indexed sections)
//   i_advance  - a record of the current section was accepted
//   i_last     - terminal index of the current section
//   o_idx      - current index
//   o_terminal - current index equals i_last
module dump_seq_counter #(
  parameter int IDX_W = 5
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_clear,
  input  logic             i_advance,
  input  logic [IDX_W-1:0] i_last,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_terminal
);

  logic [IDX_W-1:0] r_idx;
  logic             w_terminal;

  assign w_terminal = (r_idx == i_last);

  // Step the index on each accepted record; on the terminal record wrap to
  // zero so the following section starts cleanly without an extra clear.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      r_idx <= '0;
    end else if (i_advance) begin
      r_idx <= w_terminal ? '0 : r_idx + 1'b1;
    end
  end

  assign o_idx      = r_idx;
  assign o_terminal = w_terminal;

endmodule

// File: rtl/run_dump_controller.sv
// run_dump_controller
// End-of-run monitor sitting beside the single-cycle machine. While the
// program runs it gates CPU progress and (optionally) streams one PC record
// per executed cycle. On a zero instruction or a cycle timeout it freezes the
// CPU and streams a header record, the register file and a data-memory
// window over a valid/ready interface, then raises a sticky done.
// Ports:
//   i_clk, i_reset     - clock and synchronous active-high reset
//   i_inst_in, i_pc_in - current instruction and byte PC of the machine
//   o_cpu_en           - machine advances one cycle when high
//   o_rf_addr/i_rf_data   - combinational register-file read port
//   o_mem_addr/i_mem_data - combinational data-memory read port
//   o_dump_valid/i_dump_ready/o_dump_tag/o_dump_data - record stream
//   o_halt_cause       - 0 none, 1 zero instruction, 2 timeout
//   o_done             - dump complete, sticky until reset
module run_dump_controller
  import run_dump_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter int                NUM_REGS  = 32,
  parameter int                REG_AW    = 5,
  parameter int                MEM_AW    = 32,
  parameter logic [MEM_AW-1:0] MEM_BASE  = 'h4000,
  parameter int                MEM_WORDS = 4,
  parameter int                TIMEOUT   = 64,
  parameter int                TRACE_PC  = 1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [31:0]       i_inst_in,
  input  logic [31:0]       i_pc_in,
  output logic              o_cpu_en,
  output logic [REG_AW-1:0] o_rf_addr,
  input  logic [DATA_W-1:0] i_rf_data,
  output logic [MEM_AW-1:0] o_mem_addr,
  input  logic [DATA_W-1:0] i_mem_data,
  output logic              o_dump_valid,
  input  logic              i_dump_ready,
  output logic [1:0]        o_dump_tag,
  output logic [DATA_W-1:0] o_dump_data,
  output logic [1:0]        o_halt_cause,
  output logic              o_done
);

  localparam int CNT_W  = $clog2(TIMEOUT + 1);
  localparam int REG_IW = $clog2(NUM_REGS);
  localparam int MEM_IW = $clog2(MEM_WORDS);
  localparam int MAX_IW = (REG_IW > MEM_IW) ? REG_IW : MEM_IW;
  localparam int IDX_W  = (MAX_IW > 1) ? MAX_IW : 1;

  localparam logic [IDX_W-1:0] LAST_REG = IDX_W'(NUM_REGS - 1);
  localparam logic [IDX_W-1:0] LAST_MEM = IDX_W'((MEM_WORDS > 0) ? MEM_WORDS - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam bit               HAS_MEM  = (MEM_WORDS > 0);
  localparam bit               TRACE    = (TRACE_PC != 0);

  dumpState_t        r_state;
  dumpState_t        w_nextState;
  logic [CNT_W-1:0]  r_cycleCnt;
  logic [1:0]        r_haltCause;
  logic [IDX_W-1:0]  w_idx;
  logic [IDX_W-1:0]  w_idxLast;
  logic              w_idxTerminal;
  logic              w_idxClear;
  logic              w_idxAdvance;
  logic              w_haltNow;
  logic              w_valid;
  logic              w_xfer;
  logic [DATA_W-1:0] w_hdrWord;

  assign w_haltNow = (i_inst_in == '0) || (r_cycleCnt == CNT_LAST);

  // Without a PC trace every RUN cycle counts as an accepted record, so the
  // halt decision and the cycle count still advance one step per cycle.
  assign w_xfer = (r_state == RUN) ? (TRACE ? i_dump_ready : 1'b1)
                                   : (w_valid && i_dump_ready);

  assign w_idxLast    = (r_state == MEM) ? LAST_MEM : LAST_REG;
  assign w_idxClear   = !((r_state == REGS) || (r_state == MEM));
  assign w_idxAdvance = w_xfer && ((r_state == REGS) || (r_state == MEM));

  dump_seq_counter #(
    .IDX_W(IDX_W)
  ) u_idxCounter (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_clear   (w_idxClear),
    .i_advance (w_idxAdvance),
    .i_last    (w_idxLast),
    .o_idx     (w_idx),
    .o_terminal(w_idxTerminal)
  );

  // State register; reset always returns to RUN and abandons any record.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= RUN;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Executed-cycle counter and halt cause. The halting record itself is not
  // an executed cycle, so the count only moves on non-halting transfers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cycleCnt  <= '0;
      r_haltCause <= CAUSE_NONE;
    end else if ((r_state == RUN) && w_xfer) begin
      if (w_haltNow) begin
        r_haltCause <= (i_inst_in == '0) ? CAUSE_ZERO : CAUSE_TIMEOUT;
      end else begin
        r_cycleCnt <= r_cycleCnt + 1'b1;
      end
    end
  end

  // Next-state logic: each section ends on the accepted record carrying its
  // terminal index; an empty memory window skips straight to DONE.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      RUN:  if (w_xfer && w_haltNow) w_nextState = HDR;
      HDR:  if (w_xfer) w_nextState = REGS;
      REGS: if (w_xfer && w_idxTerminal) w_nextState = HAS_MEM ? MEM : DONE;
      MEM:  if (w_xfer && w_idxTerminal) w_nextState = DONE;
      DONE: w_nextState = DONE;
      default: w_nextState = RUN;
    endcase
  end

  // Header word: cause in the top two bits, executed-cycle count at the bottom.
  always_comb begin
    w_hdrWord                = '0;
    w_hdrWord[CNT_W-1:0]     = r_cycleCnt;
    w_hdrWord[31:30]         = r_haltCause;
  end

  // Output decode. Valid and cpu enable are forced low while reset is high so
  // no record can be taken and the machine cannot step during the reset cycle.
  always_comb begin
    w_valid     = 1'b0;
    o_cpu_en    = 1'b0;
    o_dump_tag  = TAG_PC;
    o_dump_data = '0;
    case (r_state)
      RUN: begin
        w_valid     = TRACE;
        o_dump_tag  = TAG_PC;
        o_dump_data = DATA_W'(i_pc_in);
        o_cpu_en    = (TRACE ? i_dump_ready : 1'b1) && !w_haltNow;
      end
      HDR: begin
        w_valid     = 1'b1;
        o_dump_tag  = TAG_HDR;
        o_dump_data = w_hdrWord;
      end
      REGS: begin
        w_valid     = 1'b1;
        o_dump_tag  = TAG_REG;
        o_dump_data = i_rf_data;
      end
      MEM: begin
        w_valid     = 1'b1;
        o_dump_tag  = TAG_MEM;
        o_dump_data = i_mem_data;
      end
      default: begin
        w_valid = 1'b0;
      end
    endcase
    if (i_reset) begin
      w_valid  = 1'b0;
      o_cpu_en = 1'b0;
    end
  end

  assign o_dump_valid = w_valid;
  assign o_rf_addr    = REG_AW'(w_idx);
  assign o_mem_addr   = MEM_BASE + MEM_AW'(w_idx);
  assign o_halt_cause = r_haltCause;
  assign o_done       = (r_state == DONE) && !i_reset;

endmodule
